// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: deserializes start/data/parity/stop frames at one bit per clock
// into a held {padding, packet} result that stays present until the consumer flushes it.
module serial_frame_receiver #(
   parameter int PACKET_W = 42,
   parameter int PAD_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                serial_in,
   output logic                sender_ack,
   input  logic                receiver_flush,
   output logic                receiver_valid,
   output logic [PAD_W-1:0]    receiver_padding,
   output logic [PACKET_W-1:0] receiver_packet,
   output logic                frame_error,
   output logic                overrun
);

   localparam int N  = PAD_W + PACKET_W;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                state, state_nx;
   logic                  armed, armed_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [N-1:0]          shreg, shreg_nx;
   logic                  par, par_nx;
   logic                  par_ok, par_ok_nx;
   logic                  valid_nx, ack_nx, err_nx, ovr_nx;
   logic [PAD_W-1:0]      pad_nx;
   logic [PACKET_W-1:0]   pkt_nx;

   // NOTE: every signal gets its hold value first so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      armed_nx  = armed;
      cnt_nx    = cnt;
      shreg_nx  = shreg;
      par_nx    = par;
      par_ok_nx = par_ok;
      valid_nx  = receiver_valid;
      pad_nx    = receiver_padding;
      pkt_nx    = receiver_packet;
      ack_nx    = 1'b0;
      err_nx    = 1'b0;
      ovr_nx    = 1'b0;

      if (receiver_flush) valid_nx = 1'b0;

      unique case (state)
         IDLE: begin
            if (serial_in) begin
               armed_nx = 1'b1;
            end else if (armed) begin
               state_nx = DATA;
               cnt_nx   = '0;
               par_nx   = 1'b0;
            end
         end
         DATA: begin
            shreg_nx = {shreg[N-2:0], serial_in};
            par_nx   = par ^ serial_in;
            cnt_nx   = cnt + CW'(1);
            if (cnt == CW'(N - 1)) state_nx = PARITY;
         end
         PARITY: begin
            par_ok_nx = ~(par ^ serial_in);
            state_nx  = STOP;
         end
         STOP: begin
            state_nx = IDLE;
            if (!par_ok || !serial_in) begin
               err_nx   = 1'b1;
               armed_nx = 1'b0;
            end else if (receiver_valid && !receiver_flush) begin
               // Buffer still held: the new frame is dropped, old result kept.
               ovr_nx   = 1'b1;
               err_nx   = 1'b1;
               armed_nx = 1'b1;
            end else begin
               valid_nx = 1'b1;
               pad_nx   = shreg[N-1 -: PAD_W];
               pkt_nx   = shreg[PACKET_W-1:0];
               ack_nx   = 1'b1;
               armed_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         armed            <= 1'b0;
         cnt              <= '0;
         shreg            <= '0;
         par              <= 1'b0;
         par_ok           <= 1'b0;
         receiver_valid   <= 1'b0;
         receiver_padding <= '0;
         receiver_packet  <= '0;
         sender_ack       <= 1'b0;
         frame_error      <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         state            <= state_nx;
         armed            <= armed_nx;
         cnt              <= cnt_nx;
         shreg            <= shreg_nx;
         par              <= par_nx;
         par_ok           <= par_ok_nx;
         receiver_valid   <= valid_nx;
         receiver_padding <= pad_nx;
         receiver_packet  <= pkt_nx;
         sender_ack       <= ack_nx;
         frame_error      <= err_nx;
         overrun          <= ovr_nx;
      end
   end

endmodule
